// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencing for ID-stage jump/branch resolution: chooses pc+2, jump
// target or hold, drives IF/ID stall/flush, and parks a taken target while fetch is busy.
module pc_redirect_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_is_ctrl,
  input  logic             id_uses_rs,
  input  logic             rs_hazard,
  input  logic             pc_sel,
  input  logic [WIDTH-1:0] pc_jump_out,
  input  logic [WIDTH-1:0] pc_add2,
  input  logic             fetch_busy,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_we,
  output logic             stall_IF_ID,
  output logic             flush_IF_ID,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {IDLE, HAZ, PEND} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tgt_q;
  logic             ctrl, blocked, run_idle, cnt_inc, tgt_ld;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign ctrl    = id_valid & id_is_ctrl;
  assign blocked = ctrl & id_uses_rs & rs_hazard;

  always_comb begin
    pc_next          = pc_add2;
    pc_we            = ~fetch_busy;
    stall_IF_ID      = fetch_busy;
    flush_IF_ID      = 1'b0;
    redirect_pending = 1'b0;
    state_nxt        = IDLE;
    cnt_inc          = 1'b0;
    tgt_ld           = 1'b0;
    run_idle         = 1'b0;

    case (state)
      IDLE: run_idle = 1'b1;
      HAZ: begin
        // A vanished instruction falls back to plain sequential fetch.
        if (id_valid && rs_hazard) begin
          stall_IF_ID = 1'b1;
          pc_we       = 1'b0;
          state_nxt   = HAZ;
        end else if (id_valid) begin
          run_idle = 1'b1;
        end
      end
      PEND: begin
        redirect_pending = 1'b1;
        pc_next          = tgt_q;
        stall_IF_ID      = 1'b0;
        flush_IF_ID      = 1'b1;
        pc_we            = ~fetch_busy;
        if (fetch_busy) state_nxt = PEND;
        else            cnt_inc   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Resolution rules shared by IDLE and a hazard that clears this cycle.
    if (run_idle) begin
      if (blocked) begin
        stall_IF_ID = 1'b1;
        pc_we       = 1'b0;
        state_nxt   = HAZ;
      end else if (ctrl && pc_sel && !fetch_busy) begin
        pc_next     = pc_jump_out;
        pc_we       = 1'b1;
        flush_IF_ID = 1'b1;
        stall_IF_ID = 1'b0;
        cnt_inc     = 1'b1;
      end else if (ctrl && pc_sel) begin
        pc_we       = 1'b0;
        flush_IF_ID = 1'b1;
        stall_IF_ID = 1'b0;
        tgt_ld      = 1'b1;
        state_nxt   = PEND;
      end
    end

    if (rst) begin
      pc_next          = '0;
      pc_we            = 1'b0;
      stall_IF_ID      = 1'b0;
      flush_IF_ID      = 1'b0;
      redirect_pending = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tgt_q        <= '0;
      redirect_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (tgt_ld)  tgt_q        <= pc_jump_out;
      if (cnt_inc) redirect_cnt <= sat_inc(redirect_cnt);
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with a queue-based scoreboard and negedge monitor.
module tb_pc_redirect_ctrl;

  localparam int W = 16;
  localparam int CW = 4;   // narrow counter so saturation is reached in a few cycles

  logic          clk, rst;
  logic          id_valid, id_is_ctrl, id_uses_rs, rs_hazard, pc_sel, fetch_busy;
  logic [W-1:0]  pc_jump_out, pc_add2, pc_next;
  logic          pc_we, stall_IF_ID, flush_IF_ID, redirect_pending;
  logic [CW-1:0] redirect_cnt;

  pc_redirect_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_is_ctrl(id_is_ctrl), .id_uses_rs(id_uses_rs),
    .rs_hazard(rs_hazard), .pc_sel(pc_sel), .pc_jump_out(pc_jump_out),
    .pc_add2(pc_add2), .fetch_busy(fetch_busy),
    .pc_next(pc_next), .pc_we(pc_we), .stall_IF_ID(stall_IF_ID),
    .flush_IF_ID(flush_IF_ID), .redirect_pending(redirect_pending),
    .redirect_cnt(redirect_cnt)
  );

  typedef struct {
    string         name;
    logic [W-1:0]  nxt;
    logic          chk;
    logic          we, st, fl, pd;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    exp_t e;
    logic [W+4+CW-1:0] act, req;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {e.chk ? pc_next : '0, pc_we, stall_IF_ID, flush_IF_ID, redirect_pending, redirect_cnt};
      req = {e.chk ? e.nxt : '0, e.we, e.st, e.fl, e.pd, e.cnt};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL %s got next/we/st/fl/pd/cnt=%h want %h", e.name, act, req);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic v, input logic c,
                      input logic u, input logic h, input logic s,
                      input logic [W-1:0] j, input logic [W-1:0] a2, input logic b,
                      input logic [W-1:0] e_nxt, input logic e_chk, input logic e_we,
                      input logic e_st, input logic e_fl, input logic e_pd,
                      input logic [CW-1:0] e_cnt);
    exp_t e;
    rst = r; id_valid = v; id_is_ctrl = c; id_uses_rs = u; rs_hazard = h;
    pc_sel = s; pc_jump_out = j; pc_add2 = a2; fetch_busy = b;
    e.name = nm; e.nxt = e_nxt; e.chk = e_chk; e.we = e_we; e.st = e_st;
    e.fl = e_fl; e.pd = e_pd; e.cnt = e_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_is_ctrl = 0; id_uses_rs = 0; rs_hazard = 0;
    pc_sel = 0; pc_jump_out = '0; pc_add2 = '0; fetch_busy = 0;
    @(posedge clk);
    #1;
    //    name           rst v c u h s  jump     add2     b  e_next   chk we st fl pd cnt
    step("rst_a",        1, 1,1,0,0,1, 16'h0040,16'h1111,0, 16'h0000,1, 0, 0, 0, 0, 0);
    step("rst_b",        1, 1,1,1,1,0, 16'h7777,16'h2222,1, 16'h0000,1, 0, 0, 0, 0, 0);
    step("post_rst_seq", 0, 1,0,0,0,0, 16'h9999,16'h0002,0, 16'h0002,1, 1, 0, 0, 0, 0);
    step("taken_idle",   0, 1,1,0,0,1, 16'h0040,16'h0004,0, 16'h0040,1, 1, 0, 1, 0, 0);
    step("seq_cnt1",     0, 1,0,0,0,0, 16'h0000,16'h0042,0, 16'h0042,1, 1, 0, 0, 0, 1);
    step("jr_haz1",      0, 1,1,1,1,0, 16'hDEAD,16'h0044,0, 16'h0000,0, 0, 1, 0, 0, 1);
    step("jr_haz2",      0, 1,1,1,1,1, 16'hBEEF,16'h0044,0, 16'h0000,0, 0, 1, 0, 0, 1);
    step("jr_resolve",   0, 1,1,1,0,1, 16'h1234,16'h0044,0, 16'h1234,1, 1, 0, 1, 0, 1);
    step("seq_busy",     0, 1,0,0,0,0, 16'h0000,16'h1236,1, 16'h1236,1, 0, 1, 0, 0, 2);
    step("jump_busy",    0, 1,1,0,0,1, 16'h00A0,16'h1236,1, 16'h0000,0, 0, 0, 1, 0, 2);
    step("pend_busy1",   0, 1,1,1,1,1, 16'hFFFF,16'h1236,1, 16'h00A0,1, 0, 0, 1, 1, 2);
    step("pend_busy2",   0, 0,0,0,0,0, 16'hFFFF,16'h1236,1, 16'h00A0,1, 0, 0, 1, 1, 2);
    step("pend_apply",   0, 1,1,0,0,1, 16'hFFFF,16'h1236,0, 16'h00A0,1, 1, 0, 1, 1, 2);
    step("after_pend",   0, 1,0,0,0,0, 16'hFFFF,16'h00A2,0, 16'h00A2,1, 1, 0, 0, 0, 3);
    step("jump_busy2",   0, 1,1,0,0,1, 16'h00A0,16'h00A2,1, 16'h0000,0, 0, 0, 1, 0, 3);
    step("pend_hold",    0, 1,0,0,0,0, 16'hFFFF,16'h00A2,1, 16'h00A0,1, 0, 0, 1, 1, 3);
    step("rst_in_pend",  1, 1,1,0,0,1, 16'hFFFF,16'h00A2,0, 16'h0000,1, 0, 0, 0, 0, 3);
    step("pend_dropped", 0, 1,0,0,0,0, 16'h00A0,16'h0010,0, 16'h0010,1, 1, 0, 0, 0, 0);
    step("haz_enter",    0, 1,1,1,1,0, 16'h0000,16'h0012,0, 16'h0000,0, 0, 1, 0, 0, 0);
    step("haz_novalid",  0, 0,1,1,1,1, 16'h3333,16'h0020,0, 16'h0020,1, 1, 0, 0, 0, 0);
    step("idle_again",   0, 1,0,0,1,0, 16'h3333,16'h0022,0, 16'h0022,1, 1, 0, 0, 0, 0);
    step("haz_enter2",   0, 1,1,1,1,0, 16'h0000,16'h0024,0, 16'h0000,0, 0, 1, 0, 0, 0);
    step("haz_to_pend",  0, 1,1,1,0,1, 16'h0300,16'h0024,1, 16'h0000,0, 0, 0, 1, 0, 0);
    step("haz_pend_app", 0, 1,1,1,1,0, 16'h4444,16'h0024,0, 16'h0300,1, 1, 0, 1, 1, 0);
    step("not_taken",    0, 1,1,0,0,0, 16'h5555,16'h0302,0, 16'h0302,1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 14; i++)
      step("cnt_ramp",   0, 1,1,0,0,1, 16'h0100 + 16'(i),16'h0000,0, 16'h0100 + 16'(i),1, 1, 0, 1, 0, 4'(1 + i));
    for (int i = 0; i < 3; i++)
      step("cnt_sat",    0, 1,1,0,0,1, 16'h0200 + 16'(i),16'h0000,0, 16'h0200 + 16'(i),1, 1, 0, 1, 0, 4'hF);
    step("sat_hold",     0, 1,1,0,0,0, 16'h5555,16'h0400,0, 16'h0400,1, 1, 0, 0, 0, 4'hF);
    step("sat_seq",      0, 0,0,0,0,0, 16'h0000,16'h0402,0, 16'h0402,1, 1, 0, 0, 0, 4'hF);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
